// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: bridges a 32-bit pipeline MEM-stage access onto a byte-wide handshaked memory port
//   Parameters: BASE_ADDR      - byte offset removed from the word-aligned pipeline address
//               TIMEOUT_CYCLES - per-byte ack wait limit (MEM_TIMEOUT_EN builds only)
//   Pipeline:   MEM_W_EN, MEM_R_EN, ALU_res (byte address), Val_Rm (write word) in;
//               MEM_out (last read word), ready (1 = advance, 0 = freeze), err (timeout flag) out
//   Memory:     mem_req, mem_we, mem_addr, mem_wdata out; mem_rdata, mem_ack in
//   Option:     define MEM_TIMEOUT_EN to abort an access whose byte is not acked in time
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'd1024,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_W_EN,
    input  logic        MEM_R_EN,
    input  logic [31:0] ALU_res,
    input  logic [31:0] Val_Rm,
    output logic [31:0] MEM_out,
    output logic        ready,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state;
    logic [31:0] base;
    logic [31:0] wword;
    logic [31:0] rbuf;
    logic        we;
    logic [1:0]  idx;
    logic        req_in;
    assign req_in    = MEM_W_EN | MEM_R_EN;
    assign ready     = (state == IDLE && !req_in) || state == DONE;
    assign mem_req   = state == ACCESS;
    assign mem_we    = we;
    assign mem_addr  = {base[31:2], idx};
    assign mem_wdata = wword[{idx, 3'b000} +: 8];
`ifdef MEM_TIMEOUT_EN
    logic [7:0] tcnt;
`else
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            rbuf    <= 32'd0;
            MEM_out <= 32'd0;
            base    <= 32'd0;
            wword   <= 32'd0;
            we      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tcnt    <= 8'd0;
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_in) begin
                    base  <= {ALU_res[31:2], 2'b00} - BASE_ADDR;
                    wword <= Val_Rm;
                    // a simultaneous read request is dropped: write wins
                    we    <= MEM_W_EN;
                    idx   <= 2'd0;
`ifdef MEM_TIMEOUT_EN
                    tcnt  <= 8'd0;
`endif
                    state <= ACCESS;
                end
                ACCESS: if (mem_ack) begin
                    if (!we) rbuf[{idx, 3'b000} +: 8] <= mem_rdata;
                    idx <= idx + 2'd1;
`ifdef MEM_TIMEOUT_EN
                    tcnt <= 8'd0;
`endif
                    if (idx == 2'd3) begin
                        state <= DONE;
                        // publish the word as the last byte lands so DONE already shows it
                        if (!we) MEM_out <= {mem_rdata, rbuf[23:0]};
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (tcnt == TIMEOUT_CYCLES - 8'd1) begin
                    state <= DONE;
                    err   <= 1'b1;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
`endif
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector bench for mem_access_ctrl
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_W_EN, MEM_R_EN;
    logic [31:0] ALU_res, Val_Rm, MEM_out, mem_addr;
    logic        ready, err, mem_req, mem_we, mem_ack;
    logic [7:0]  mem_wdata, mem_rdata;
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    mem_access_ctrl #(.BASE_ADDR(32'd1024), .TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .rst(rst), .MEM_W_EN(MEM_W_EN), .MEM_R_EN(MEM_R_EN),
        .ALU_res(ALU_res), .Val_Rm(Val_Rm), .MEM_out(MEM_out), .ready(ready),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );
    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] alu;
        logic [31:0] val;
        logic [31:0] rdw;
        int          gap;
        logic [31:0] base;
        logic [31:0] mout;
    } vec_t;
    vec_t vecs[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic txn(input vec_t v);
        int acc;
        MEM_W_EN = v.we;
        MEM_R_EN = v.re;
        ALU_res  = v.alu;
        Val_Rm   = v.val;
        #1;
        chk("ready_on_request", ready, 0);
        chk("req_before_accept", mem_req, 0);
        cyc();
        MEM_W_EN = 0;
        MEM_R_EN = 0;
        ALU_res  = ~v.alu;
        Val_Rm   = ~v.val;
        acc = 0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < v.gap; g++) begin
                mem_ack = 0;
                #1;
                chk("req_wait", mem_req, 1);
                chk("addr_wait", mem_addr, v.base + b);
                acc++;
                cyc();
            end
            mem_ack   = 1;
            mem_rdata = v.we ? 8'hEE : v.rdw[b*8 +: 8];
            #1;
            chk("req", mem_req, 1);
            chk("addr", mem_addr, v.base + b);
            chk("we", mem_we, v.we);
            if (v.we) chk("wdata", mem_wdata, v.val[b*8 +: 8]);
            chk("ready_access", ready, 0);
            acc++;
            cyc();
        end
        mem_ack = 0;
        #1;
        chk("done_req", mem_req, 0);
        chk("done_ready", ready, 1);
        chk("done_mem_out", MEM_out, v.mout);
        chk("access_cycles", acc, 4 * (v.gap + 1));
        cyc();
        #1;
        chk("idle_ready", ready, 1);
        chk("idle_req", mem_req, 0);
        chk("hold_mem_out", MEM_out, v.mout);
    endtask
    initial begin
        vecs[0] = '{1, 0, 32'h404,  32'hAABBCCDD, 32'h0,        0, 32'h4,        32'h0};
        vecs[1] = '{0, 1, 32'h406,  32'h0,        32'h44332211, 1, 32'h4,        32'h44332211};
        vecs[2] = '{1, 1, 32'h404,  32'h12345678, 32'h0,        0, 32'h4,        32'h44332211};
        vecs[3] = '{0, 1, 32'h0,    32'h0,        32'hCAFEF00D, 0, 32'hFFFFFC00, 32'hCAFEF00D};
        vecs[4] = '{1, 0, 32'h7FF,  32'h01020304, 32'h0,        2, 32'h3FC,      32'hCAFEF00D};
        vecs[5] = '{0, 1, 32'h1234, 32'h0,        32'hDEADBEEF, 0, 32'hE34,      32'hDEADBEEF};
        rst = 1; MEM_W_EN = 0; MEM_R_EN = 0; ALU_res = 0; Val_Rm = 0;
        mem_ack = 0; mem_rdata = 0;
        cyc();
        cyc();
        rst = 0;
        #1;
        chk("rst_mem_out", MEM_out, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_ready", ready, 1);
        chk("rst_err", err, 0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) txn(vecs[i]);
        // reset after the second ack of a read
        MEM_R_EN = 1; ALU_res = 32'h406;
        cyc();
        MEM_R_EN = 0;
        mem_ack = 1; mem_rdata = 8'h11;
        cyc();
        mem_rdata = 8'h22;
        cyc();
        mem_ack = 0; rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_mem_out", MEM_out, 0);
        chk("abort_ready", ready, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("abort_no_done", mem_req, 0);
            chk("abort_out_hold", MEM_out, 0);
        end
        @(negedge clk);
        txn('{0, 1, 32'h500, 32'h0, 32'h0BADCAFE, 0, 32'h100, 32'h0BADCAFE});
        // read with no ack
        MEM_R_EN = 1; ALU_res = 32'h404;
        cyc();
        MEM_R_EN = 0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_req", mem_req, 1);
            cyc();
        end
        #1;
        chk("to_done_req", mem_req, 0);
        chk("to_done_ready", ready, 1);
        chk("to_err", err, 1);
        chk("to_mem_out", MEM_out, 32'h0BADCAFE);
        cyc();
        txn('{0, 1, 32'h404, 32'h0, 32'h01020304, 0, 32'h4, 32'h01020304});
        #1;
        chk("to_err_sticky", err, 1);
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("to_err_cleared", err, 0);
`else
        for (int i = 0; i < 100; i++) begin
            #1;
            chk("wait_req", mem_req, 1);
            chk("wait_err", err, 0);
            chk("wait_ready", ready, 0);
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("wait_rst_req", mem_req, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
